// File: rtl/mod_mul_seq.sv
// Sequential modular-multiply front end: constant-time radix-2 shift-add product of two
// signed-magnitude operands, handed to the downstream Barrett reducer over enable/valid.
module mod_mul_seq #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   op_a,
  input  logic           sign_a,
  input  logic [W-1:0]   op_b,
  input  logic           sign_b,
  output logic           busy,
  output logic           red_enable,
  output logic [2*W-1:0] red_a,
  output logic           red_sign,
  input  logic           red_valid,
  input  logic [W-1:0]   red_result,
  output logic           valid,
  output logic [W-1:0]   result
);

  localparam int CNT_W = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic             sgn_q, sgn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   red_a_q, red_a_d;
  logic             red_sign_q, red_sign_d;
  logic [W-1:0]     result_q, result_d;
  logic             valid_q, valid_d;

  logic [W:0]       partial;
  logic [2*W-1:0]   acc_shift;
  logic             last_iter;

  // One LSB-first iteration: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    partial   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : {W{1'b0}})};
    acc_shift = {partial, acc_q[W-1:1]};
    last_iter = (cnt_q == CNT_W'(W - 1));
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    sgn_d      = sgn_q;
    cnt_d      = cnt_q;
    red_a_d    = red_a_q;
    red_sign_d = red_sign_q;
    result_d   = result_q;
    valid_d    = valid_q;
    busy       = 1'b0;
    red_enable = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = op_a;
          acc_d   = {{W{1'b0}}, op_b};
          sgn_d   = sign_a ^ sign_b;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = MULT;
        end
      end
      MULT: begin
        busy  = 1'b1;
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // A zero product is sent as positive so the reducer cannot answer p.
          red_a_d    = acc_shift;
          red_sign_d = sgn_q & (acc_shift != '0);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        red_enable = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (red_valid) begin
          result_d = red_result;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      acc_q      <= '0;
      sgn_q      <= 1'b0;
      cnt_q      <= '0;
      red_a_q    <= '0;
      red_sign_q <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      sgn_q      <= sgn_d;
      cnt_q      <= cnt_d;
      red_a_q    <= red_a_d;
      red_sign_q <= red_sign_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign red_a    = red_a_q;
  assign red_sign = red_sign_q;
  assign result   = result_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed bench for mod_mul_seq with a behavioural 3-cycle Barrett reducer that
// keeps its done flag and old result high until it is re-enabled.
module tb_mod_mul_seq;

  localparam int W = 64;
  localparam logic [63:0]  P      = 64'h989D4E43F57FCF45;
  localparam logic [127:0] PM1_SQ = {64'd0, P - 64'd1} * {64'd0, P - 64'd1};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic           sign_a = 1'b0;
  logic [W-1:0]   op_b = '0;
  logic           sign_b = 1'b0;
  logic           busy;
  logic           red_enable;
  logic [2*W-1:0] red_a;
  logic           red_sign;
  logic           red_valid = 1'b0;
  logic [W-1:0]   red_result = '0;
  logic           valid;
  logic [W-1:0]   result;

  int total = 0;
  int bad = 0;

  mod_mul_seq #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .sign_a     (sign_a),
    .op_b       (op_b),
    .sign_b     (sign_b),
    .busy       (busy),
    .red_enable (red_enable),
    .red_a      (red_a),
    .red_sign   (red_sign),
    .red_valid  (red_valid),
    .red_result (red_result),
    .valid      (valid),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Naive signed reduction: a negative input yields p - (|a| mod p).
  function automatic logic [63:0] reduce(input logic [127:0] a, input logic s);
    logic [127:0] r;
    r = a % {64'd0, P};
    return s ? (P - r[63:0]) : r[63:0];
  endfunction

  // Reducer model: red_enable clears the done flag; three cycles later it sets
  // the result and holds done high until the next enable.
  logic [1:0]   m_cnt = 2'd0;
  logic         m_busy = 1'b0;
  logic [127:0] m_a = '0;
  logic         m_s = 1'b0;

  always @(posedge clk) begin
    if (red_enable) begin
      m_busy    <= 1'b1;
      m_cnt     <= 2'd2;
      red_valid <= 1'b0;
      m_a       <= red_a;
      m_s       <= red_sign;
    end else if (m_busy) begin
      if (m_cnt == 2'd0) begin
        red_valid  <= 1'b1;
        red_result <= reduce(m_a, m_s);
        m_busy     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy"},       128'(busy),       128'd0);
    checkOutput({tag, " red_enable"}, 128'(red_enable), 128'd0);
    checkOutput({tag, " red_a"},      128'(red_a),      128'd0);
    checkOutput({tag, " red_sign"},   128'(red_sign),   128'd0);
    checkOutput({tag, " valid"},      128'(valid),      128'd0);
    checkOutput({tag, " result"},     128'(result),     128'd0);
  endtask

  // Issues one operation from the current cycle and follows it to the valid cycle.
  // Operand inputs are scrambled after the start edge; junk adds ignored starts
  // in cycles 10 (MULT) and 66 (WAIT).
  task automatic applyStimulus(input logic [63:0] a, input logic sa, input logic [63:0] b,
                               input logic sb, input logic [127:0] exp_a, input logic exp_s,
                               input logic [63:0] exp_r, input bit junk, input string tag);
    int en_first = 0;
    int en_cnt = 0;
    int valid_cyc = 0;
    int busy_gap = 0;
    op_a = a; sign_a = sa; op_b = b; sign_b = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = 64'h1234_5678_9ABC_DEF1; op_b = 64'h0FED_CBA9_8765_4321;
    sign_a = ~sa; sign_b = 1'b0;
    checkOutput({tag, " valid cleared"}, 128'(valid), 128'd0);
    for (int cyc = 1; cyc <= 150 && valid_cyc == 0; cyc++) begin
      start = 1'b0;
      if (red_enable) begin
        en_cnt++;
        if (en_first == 0) en_first = cyc;
      end
      if (cyc == 65) begin
        checkOutput({tag, " red_a issue"},    red_a,             exp_a);
        checkOutput({tag, " red_sign issue"}, 128'(red_sign),    128'(exp_s));
      end
      if (valid) begin
        valid_cyc = cyc;
        checkOutput({tag, " busy at valid"}, 128'(busy), 128'd0);
      end else if (!busy && busy_gap == 0) begin
        busy_gap = cyc;
      end
      if (junk && (cyc == 10 || cyc == 66)) start = 1'b1;
      if (valid_cyc == 0) begin
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, " valid cycle"},    128'(valid_cyc), 128'd70);
    checkOutput({tag, " enable cycle"},   128'(en_first),  128'd65);
    checkOutput({tag, " enable pulses"},  128'(en_cnt),    128'd1);
    checkOutput({tag, " busy gap cycle"}, 128'(busy_gap),  128'd0);
    checkOutput({tag, " result"},         128'(result),    128'(exp_r));
    checkOutput({tag, " red_a held"},     red_a,           exp_a);
  endtask

  initial begin
    #12;
    checkResetOutputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(64'd3, 1'b0, 64'd5, 1'b0, 128'd15, 1'b0, 64'd15, 1'b0, "3x5");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("3x5 valid hold",  128'(valid),  128'd1);
    checkOutput("3x5 result hold", 128'(result), 128'd15);

    applyStimulus(P - 64'd1, 1'b0, P - 64'd1, 1'b0, PM1_SQ, 1'b0, 64'd1, 1'b0, "pm1sq");
    applyStimulus(64'd2, 1'b1, 64'd3, 1'b0, 128'd6, 1'b1, 64'h989D4E43F57FCF3F, 1'b0, "neg2x3");
    applyStimulus(64'd2, 1'b1, 64'd3, 1'b1, 128'd6, 1'b0, 64'd6, 1'b1, "n2xn3 junk");

    // Abandon an operation in WAIT with a two-cycle reset.
    op_a = 64'd3; sign_a = 1'b0; op_b = 64'd5; sign_b = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (66) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    checkResetOutputs("async rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("rst red_enable", 128'(red_enable), 128'd0);
      checkOutput("rst busy",       128'(busy),       128'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(64'd3, 1'b0, 64'd5, 1'b0, 128'd15, 1'b0, 64'd15, 1'b0, "post-rst 3x5");
    applyStimulus(64'd0, 1'b1, 64'd7, 1'b0, 128'd0, 1'b0, 64'd0, 1'b0, "neg0x7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
